// File: rtl/dat_chunk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dat_chunk_pkg
// Brief    : Shared types and sizing helpers for the nonzero chunk
//            ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
package dat_chunk_pkg;

  // Life cycle of one bank: empty, partially written, holding a full chunk
  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } bank_state_e;

  typedef logic [7:0] byte_t;

  localparam int MEM_SIZE_DEF = 32;
  // Wide enough to hold a count of MEM_SIZE itself (addresses run 1..MEM_SIZE)
  localparam int ADDR_W = $clog2(MEM_SIZE_DEF) + 1;

  function automatic int addr_width(input int mem_size);
    return $clog2(mem_size) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dat_chunk_nz_pack.sv
`default_nettype none
// ============================================================================
// Module   : dat_chunk_nz_pack
// Brief    : Per-beat nonzero analysis: nonzero mask, exclusive prefix count
//            of nonzero bytes ahead of each byte, and beat nonzero total.
// Revision : 1.0 - initial release
// ============================================================================
module dat_chunk_nz_pack
  import dat_chunk_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int CNT_W      = ADDR_W
) (
  input  logic [BEAT_BYTES*8-1:0]     i_beat_data,
  output logic [BEAT_BYTES-1:0]       o_nz_mask,
  output logic [BEAT_BYTES*CNT_W-1:0] o_prefix_cnt,
  output logic [CNT_W-1:0]            o_beat_total
);

  logic [CNT_W-1:0] w_run;

  // Running count over bytes, oldest (byte 0) first
  always_comb begin
    w_run        = '0;
    o_nz_mask    = '0;
    o_prefix_cnt = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      o_nz_mask[b]                    = |i_beat_data[b*8 +: 8];
      o_prefix_cnt[b*CNT_W +: CNT_W]  = w_run;
      w_run                           = w_run + CNT_W'(o_nz_mask[b]);
    end
    o_beat_total = w_run;
  end

endmodule
`default_nettype wire

// File: rtl/dat_chunk_nz_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : dat_chunk_nz_pingpong_buf
// Brief    : Packs the nonzero bytes of dense beats into one of two banks
//            (addresses 1..MEM_SIZE) and hands full banks to the read stage
//            under a valid/done ping-pong handshake.
// Options  : DAT_CHUNK_ZERO_CLR_EN - zero a bank's bytes when it is released
// Revision : 1.0 - initial release
// ============================================================================
module dat_chunk_nz_pingpong_buf
  import dat_chunk_pkg::*;
#(
  parameter int MEM_SIZE   = MEM_SIZE_DEF,
  parameter int BEAT_BYTES = 4            // must not exceed MEM_SIZE
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  input  logic [BEAT_BYTES*8-1:0]            wr_data_i,
  input  logic                               wr_last_i,
  output logic                               rd_valid_o,
  input  logic                               rd_done_i,
  output logic                               rd_sel_o,
  output logic [2*MEM_SIZE*8-1:0]            rd_nonzero_data_o,
  output logic [2*($clog2(MEM_SIZE)+1)-1:0]  rd_nz_cnt_o,
  output logic                               ovf_o
);

  localparam int c_addr_w = addr_width(MEM_SIZE);
  // One extra bit so ptr + prefix + 1 never wraps before the range check
  localparam int c_tgt_w  = c_addr_w + 1;

  bank_state_e                      r_state [2];
  logic                             r_wr_bank;
  logic                             r_rd_sel;
  logic                             r_ovf;
  logic [c_addr_w-1:0]              r_wr_ptr;
  logic [1:0][c_addr_w-1:0]         r_cnt;
  byte_t [1:0][MEM_SIZE:1]          r_mem;

  logic [BEAT_BYTES-1:0]            w_nz_mask;
  logic [BEAT_BYTES*c_addr_w-1:0]   w_prefix;
  logic [c_addr_w-1:0]              w_beat_total;
  logic                             w_acc;
  logic                             w_rel;
  logic [c_tgt_w-1:0]               w_tgt [BEAT_BYTES];
  logic [c_tgt_w-1:0]               w_sum;
  logic [c_addr_w-1:0]              w_ptr_nxt;
  logic [MEM_SIZE:1]                w_we;
  byte_t [MEM_SIZE:1]               w_wdata;
  logic                             w_drop;

  dat_chunk_nz_pack #(
    .BEAT_BYTES (BEAT_BYTES),
    .CNT_W      (c_addr_w)
  ) u_nz_pack (
    .i_beat_data  (wr_data_i),
    .o_nz_mask    (w_nz_mask),
    .o_prefix_cnt (w_prefix),
    .o_beat_total (w_beat_total)
  );

  assign wr_ready_o        = (r_state[r_wr_bank] != FULL);
  assign rd_valid_o        = (r_state[r_rd_sel] == FULL);
  assign rd_sel_o          = r_rd_sel;
  assign ovf_o             = r_ovf;
  assign rd_nonzero_data_o = r_mem;
  assign rd_nz_cnt_o       = r_cnt;

  assign w_acc     = wr_valid_i & wr_ready_o;
  assign w_rel     = rd_done_i & rd_valid_o;
  assign w_sum     = c_tgt_w'(r_wr_ptr) + c_tgt_w'(w_beat_total);
  assign w_ptr_nxt = (w_sum > c_tgt_w'(MEM_SIZE)) ? c_addr_w'(MEM_SIZE)
                                                  : w_sum[c_addr_w-1:0];

  // Scatter nonzero bytes to their packed addresses; flag any past the bank end
  always_comb begin
    w_we    = '0;
    w_wdata = '0;
    w_drop  = 1'b0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      w_tgt[b] = c_tgt_w'(r_wr_ptr) + c_tgt_w'(w_prefix[b*c_addr_w +: c_addr_w])
               + c_tgt_w'(1);
      if (w_acc && w_nz_mask[b]) begin
        if (w_tgt[b] > c_tgt_w'(MEM_SIZE)) begin
          w_drop = 1'b1;
        end else begin
          for (int a = 1; a <= MEM_SIZE; a++) begin
            if (w_tgt[b] == c_tgt_w'(a)) begin
              w_we[a]    = 1'b1;
              w_wdata[a] = wr_data_i[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Bank state machine, write pointer, per-bank counts and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state[0] <= FREE;
      r_state[1] <= FREE;
      r_wr_bank  <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      // Writer only touches a non-FULL bank, reader only a FULL one, so
      // both updates may land in the same cycle without conflict.
      if (w_acc) begin
        r_state[r_wr_bank] <= wr_last_i ? FULL : FILL;
        if (wr_last_i) begin
          r_cnt[r_wr_bank] <= w_ptr_nxt;
          r_wr_ptr         <= '0;
          r_wr_bank        <= ~r_wr_bank;
        end else begin
          r_wr_ptr         <= w_ptr_nxt;
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
      if (w_rel) begin
        r_state[r_rd_sel] <= FREE;
        r_rd_sel          <= ~r_rd_sel;
      end
    end
  end

  // Bank byte storage: packed writes into the writer's bank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 1; a <= MEM_SIZE; a++) begin
`ifdef DAT_CHUNK_ZERO_CLR_EN
          if (w_rel && (r_rd_sel == 1'(k))) begin
            r_mem[k][a] <= '0;
          end else if (w_we[a] && (r_wr_bank == 1'(k))) begin
            r_mem[k][a] <= w_wdata[a];
          end
`else
          if (w_we[a] && (r_wr_bank == 1'(k))) begin
            r_mem[k][a] <= w_wdata[a];
          end
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dat_chunk_nz_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_chunk_nz_pingpong_buf
// Brief    : Self-checking bench for the nonzero chunk ping-pong buffer
//            (MEM_SIZE=8, BEAT_BYTES=4). Honours DAT_CHUNK_ZERO_CLR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dat_chunk_nz_pingpong_buf;

  localparam int MEM = 8;
  localparam int BB  = 4;
  localparam int AW  = 4;

  logic              clk_i      = 1'b0;
  logic              rst_ni     = 1'b0;
  logic              wr_valid_i = 1'b0;
  logic              wr_last_i  = 1'b0;
  logic              rd_done_i  = 1'b0;
  logic [BB*8-1:0]   wr_data_i  = '0;
  logic              wr_ready_o;
  logic              rd_valid_o;
  logic              rd_sel_o;
  logic [2*MEM*8-1:0] rd_nonzero_data_o;
  logic [2*AW-1:0]   rd_nz_cnt_o;
  logic              ovf_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit               bank;
    logic [AW-1:0]    cnt;
    logic [8*MEM-1:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_mem [2][1:MEM];
  int         m_ptr;
  bit         m_bank;
  bit         m_ovf;

  dat_chunk_nz_pingpong_buf #(
    .MEM_SIZE   (MEM),
    .BEAT_BYTES (BB)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .wr_valid_i        (wr_valid_i),
    .wr_ready_o        (wr_ready_o),
    .wr_data_i         (wr_data_i),
    .wr_last_i         (wr_last_i),
    .rd_valid_o        (rd_valid_o),
    .rd_done_i         (rd_done_i),
    .rd_sel_o          (rd_sel_o),
    .rd_nonzero_data_o (rd_nonzero_data_o),
    .rd_nz_cnt_o       (rd_nz_cnt_o),
    .ovf_o             (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [8*MEM-1:0] bank_flat(input bit k);
    logic [8*MEM-1:0] r;
    r = '0;
    for (int a = 1; a <= MEM; a++) r[(a-1)*8 +: 8] = m_mem[k][a];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 1; a <= MEM; a++) m_mem[k][a] = 8'h00;
    m_ptr  = 0;
    m_bank = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [BB*8-1:0] d, input bit l);
    exp_t       e;
    logic [7:0] by;
    for (int b = 0; b < BB; b++) begin
      by = d[b*8 +: 8];
      if (by != 8'h00) begin
        if (m_ptr < MEM) begin
          m_ptr++;
          m_mem[m_bank][m_ptr] = by;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (l) begin
      e.bank = m_bank;
      e.cnt  = AW'(m_ptr);
      e.data = bank_flat(m_bank);
      sb.push_back(e);
      m_ptr  = 0;
      m_bank = ~m_bank;
    end
  endtask

  task automatic model_release(input bit k);
`ifdef DAT_CHUNK_ZERO_CLR_EN
    for (int a = 1; a <= MEM; a++) m_mem[k][a] = 8'h00;
`else
    if (k > 1'b1) m_ptr = m_ptr;
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst_ni     = 1'b0;
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    rd_done_i  = 1'b0;
    wr_data_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_beat(input logic [BB*8-1:0] d, input bit l);
    int waits = 0;
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_last_i  = l;
    while (!wr_ready_o && waits < 20) begin
      @(negedge clk_i);
      waits++;
    end
    if (!wr_ready_o) begin
      total++;
      bad++;
      $display("FAIL send_timeout: wr_ready_o=%b required 1", wr_ready_o);
    end else begin
      model_accept(d, l);
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  // Wait for a full bank, compare it with the oldest scoreboard entry
  task automatic consume(input bit do_release);
    int   waits = 0;
    exp_t e;
    while (!rd_valid_o && waits < 20) begin
      @(negedge clk_i);
      waits++;
    end
    total++;
    if (!rd_valid_o) begin
      bad++;
      $display("FAIL consume_timeout: rd_valid_o=%b required 1", rd_valid_o);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL consume_unexpected: rd_valid_o=1 with no chunk expected");
    end else begin
      e = sb.pop_front();
      total++;
      if (rd_sel_o !== e.bank) begin
        bad++;
        $display("FAIL rd_sel: got %b required %b", rd_sel_o, e.bank);
      end
      total++;
      if (rd_nz_cnt_o[e.bank*AW +: AW] !== e.cnt) begin
        bad++;
        $display("FAIL nz_cnt bank%0d: got %0d required %0d", e.bank,
                 rd_nz_cnt_o[e.bank*AW +: AW], e.cnt);
      end
      total++;
      if (rd_nonzero_data_o[e.bank*8*MEM +: 8*MEM] !== e.data) begin
        bad++;
        $display("FAIL bank_data bank%0d: got %h required %h", e.bank,
                 rd_nonzero_data_o[e.bank*8*MEM +: 8*MEM], e.data);
      end
      total++;
      if (ovf_o !== m_ovf) begin
        bad++;
        $display("FAIL ovf: got %b required %b", ovf_o, m_ovf);
      end
      if (do_release) begin
        rd_done_i = 1'b1;
        @(negedge clk_i);
        rd_done_i = 1'b0;
        model_release(e.bank);
        total++;
        if (rd_sel_o !== !e.bank) begin
          bad++;
          $display("FAIL rd_sel_toggle: got %b required %b", rd_sel_o, !e.bank);
        end
        total++;
        if (rd_nonzero_data_o[e.bank*8*MEM +: 8*MEM] !== bank_flat(e.bank)) begin
          bad++;
          $display("FAIL release_data bank%0d: got %h required %h", e.bank,
                   rd_nonzero_data_o[e.bank*8*MEM +: 8*MEM], bank_flat(e.bank));
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (rd_nonzero_data_o !== '0) begin
      bad++;
      $display("FAIL %s data: got %h required 0", tag, rd_nonzero_data_o);
    end
    total++;
    if (rd_nz_cnt_o !== '0) begin
      bad++;
      $display("FAIL %s cnt: got %h required 0", tag, rd_nz_cnt_o);
    end
    total++;
    if ({wr_ready_o, rd_valid_o, rd_sel_o, ovf_o} !== 4'b1000) begin
      bad++;
      $display("FAIL %s flags(ready,valid,sel,ovf): got %b required 1000",
               tag, {wr_ready_o, rd_valid_o, rd_sel_o, ovf_o});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    check_idle("reset");
  endtask

  task automatic test_single_beat();
    apply_reset();
    send_beat(32'h0007_0005, 1'b1);
    total++;
    if (rd_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL single_latency rd_valid: got %b required 1", rd_valid_o);
    end
    total++;
    if (rd_nonzero_data_o[15:0] !== 16'h0705) begin
      bad++;
      $display("FAIL single_bytes: got %h required 0705", rd_nonzero_data_o[15:0]);
    end
    consume(1'b1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_beat(32'h0403_0201, 1'b1);
    send_beat(32'h0800_0009, 1'b1);
    total++;
    if (wr_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL both_full ready: got %b required 0", wr_ready_o);
    end
    // Offer a third beat; it must stall while both banks are full
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h0C00_0B0A;
    wr_last_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    total++;
    if (wr_ready_o !== 1'b0 || rd_nz_cnt_o[AW-1:0] !== 4'd4) begin
      bad++;
      $display("FAIL stall: ready=%b cnt0=%0d required ready=0 cnt0=4",
               wr_ready_o, rd_nz_cnt_o[AW-1:0]);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    consume(1'b1);
    total++;
    if (wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release: got %b required 1", wr_ready_o);
    end
    consume(1'b0);
    // Last beat into bank0 and release of bank1 on the same edge
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h0C00_0B0A;
    wr_last_i  = 1'b1;
    rd_done_i  = 1'b1;
    model_accept(32'h0C00_0B0A, 1'b1);
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    rd_done_i  = 1'b0;
    model_release(1'b1);
    total++;
    if ({rd_sel_o, rd_valid_o, wr_ready_o} !== 3'b011) begin
      bad++;
      $display("FAIL simultaneous(sel,valid,ready): got %b required 011",
               {rd_sel_o, rd_valid_o, wr_ready_o});
    end
    consume(1'b1);
  endtask

  task automatic test_overflow();
    apply_reset();
    send_beat(32'h1413_1211, 1'b0);
    send_beat(32'h1817_1615, 1'b0);
    total++;
    if (ovf_o !== 1'b0 || rd_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL exactly_full: ovf=%b valid=%b required 0 0", ovf_o, rd_valid_o);
    end
    send_beat(32'h1C1B_1A19, 1'b1);
    total++;
    if (ovf_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b required 1", ovf_o);
    end
    consume(1'b1);
    total++;
    if (ovf_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %b required 1", ovf_o);
    end
  endtask

  task automatic test_all_zero();
    apply_reset();
    send_beat(32'h0000_0000, 1'b1);
    consume(1'b1);
    // Done with no valid bank must be ignored
    rd_done_i = 1'b1;
    @(negedge clk_i);
    rd_done_i = 1'b0;
    total++;
    if (rd_sel_o !== 1'b1 || rd_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stray_done: sel=%b valid=%b required 1 0", rd_sel_o, rd_valid_o);
    end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    send_beat(32'hCC00_BBAA, 1'b0);
    total++;
    if (rd_nonzero_data_o[7:0] !== 8'hAA) begin
      bad++;
      $display("FAIL partial_write: got %h required aa", rd_nonzero_data_o[7:0]);
    end
    rst_ni = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    send_beat(32'h0022_0021, 1'b1);
    consume(1'b1);
  endtask

  task automatic test_zero_clr();
    logic [31:0] exp_word;
    apply_reset();
    send_beat(32'h0807_0605, 1'b1);
    consume(1'b1);
`ifdef DAT_CHUNK_ZERO_CLR_EN
    exp_word = 32'h0000_0000;
`else
    exp_word = 32'h0807_0605;
`endif
    total++;
    if (rd_nonzero_data_o[31:0] !== exp_word) begin
      bad++;
      $display("FAIL released_bank0: got %h required %h", rd_nonzero_data_o[31:0], exp_word);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_overflow();
    test_all_zero();
    test_reset_mid_fill();
    test_zero_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
